wavetable_fetch: RTL and testbench
==================================

Name: wavetable_fetch

Overview:
Per-voice wavetable read stage that sits directly upstream of the 6-bit linear interpolator.
- On each audio-rate tick, advances a phase accumulator and fetches two adjacent table entries from a synchronous ROM.
- Presents the two entries together with the 6-bit fractional phase as a registered, one-cycle-valid bundle: SAMPLE_1, SAMPLE_2, SEL.

Parameters:
IDX_W, 8, table index width (table holds 2^IDX_W entries per waveform)
TBL_W, 2, waveform select width
LSB_W, 10, sub-fraction accumulator bits below SEL
DATA_W, 16, sample width
FRAC_W is fixed at 6 and is not a parameter. PH_W = IDX_W+6+LSB_W, which is 24 at the defaults.

Ports:
CLK  in  1  system clock
RESET  in  1  synchronous, active-high reset
SAMPLE_TICK  in  1  one-cycle audio-rate strobe
PHASE_INC  in  PH_W  phase increment per tick
PHASE_RST  in  1  one-cycle strobe: restart phase at 0
TABLE_SEL  in  TBL_W  waveform select
ROM_ADDR  out  TBL_W+IDX_W  ROM read address, registered
ROM_DATA  in  DATA_W  ROM read data, valid 1 cycle after ROM_ADDR is presented
SAMPLE_1  out  DATA_W  table[idx]
SAMPLE_2  out  DATA_W  table[idx+1]
SEL  out  6  fractional phase
VALID  out  1  one-cycle pulse: SAMPLE_1/SAMPLE_2/SEL updated
BUSY  out  1  fetch in progress (state != IDLE)
OVERRUN  out  1  sticky: a tick was dropped

Behaviour:
Interface:
- One clock (CLK). Reset (RESET) is synchronous and active-high.

Reset:
- All outputs and internal registers go to 0; state goes to IDLE.
- RESET asserted mid-fetch aborts the fetch; no VALID is produced.

Phase format (PH_W bits):
- idx = PHASE[PH_W-1 -: IDX_W]
- frac = PHASE[LSB_W+5:LSB_W]
- Low LSB_W bits accumulate only.
- Addition is unsigned modulo 2^PH_W, so the index wraps naturally.

States: IDLE, RD1, RD2, RD3.
- IDLE with SAMPLE_TICK=1:
  - Snapshot IDX_R=idx, FRAC_R=frac, TBL_R=TABLE_SEL.
  - PHASE <= PHASE + PHASE_INC.
  - ROM_ADDR <= {TABLE_SEL, idx}.
  - Go to RD1.
- RD1: ROM_ADDR <= {TBL_R, IDX_R+1} (mod 2^IDX_W); go to RD2.
- RD2: S1_R <= ROM_DATA (entry idx); go to RD3.
- RD3:
  - SAMPLE_1 <= S1_R; SAMPLE_2 <= ROM_DATA; SEL <= FRAC_R; VALID <= 1.
  - Go to IDLE.
- Latency: tick in cycle T gives VALID=1 in cycle T+4.
- Throughput: one tick per 4 cycles.

Output holding:
- VALID is high for exactly one cycle.
- SAMPLE_1, SAMPLE_2 and SEL hold their values until the next VALID.

PHASE_RST:
- Forces PHASE to 0 in any state.
- If coincident with an accepted tick, the snapshot uses phase 0 and PHASE <= PHASE_INC.
- Does not disturb a fetch in progress.

Dropped ticks:
- SAMPLE_TICK while BUSY is dropped: PHASE is not advanced and OVERRUN <= 1.
- OVERRUN clears only on RESET.

Other rules:
- PHASE_INC = 0 is legal; the same sample pair is refetched each tick.
- TABLE_SEL changes take effect at the next accepted tick only.

Optional Feature:
Macro WAVETABLE_FETCH_ONESHOT_EN.
- Defined (one-shot sample playback):
  - If PHASE + PHASE_INC would exceed 2^PH_W-1, PHASE saturates to all-ones.
  - When IDX_R = 2^IDX_W-1, the second read uses IDX_R rather than 0, so SAMPLE_2 = SAMPLE_1.
  - Extra output END (1 bit, reset 0) is set when saturation occurs and cleared by PHASE_RST or RESET.
- Undefined:
  - Free-running modulo wrap; the last entry pairs with entry 0.
  - No END port.

Test Plan:
1. Defaults, ROM[t][i] = i*256, PHASE_INC=24'h000400, ticks every 8 cycles:
   -> tick 1 gives SAMPLE_1=0, SAMPLE_2=256, SEL=0.
   -> tick 2 gives SEL=1.
   -> tick 65 gives SAMPLE_1=256, SAMPLE_2=512, SEL=0.
   -> VALID exactly 4 cycles after each tick.
2. Index wrap: PHASE_INC=24'h010000.
   -> tick 256 gives SAMPLE_1=0xFF00, SAMPLE_2=0x0000, ROM_ADDR sequence {t,FF},{t,00}.
   -> tick 257 gives idx 0.
3. Overrun: ticks at cycles T and T+2.
   -> one VALID at T+4, OVERRUN=1 from T+3 onward.
   -> phase advanced once (next tick yields SEL=1 with INC 24'h000400).
4. Reset mid-fetch: RESET at T+2 after a tick.
   -> no VALID; SAMPLE_1, SAMPLE_2, SEL, ROM_ADDR, OVERRUN all 0 from T+3.
   -> next tick fetches idx 0.
5. PHASE_RST coincident with a tick after 10 ticks of INC 24'h000400.
   -> SEL=0, SAMPLE_1=0; following tick gives SEL=1.
   -> TABLE_SEL=2 gives ROM_ADDR upper bits = 2'b10.
6. ONESHOT_EN: PHASE_INC=24'h400000.
   -> after 4 ticks PHASE=24'hFFFFFF and END=1.
   -> subsequent outputs SAMPLE_1=SAMPLE_2=0xFF00, SEL=63.
   -> PHASE_RST clears END.

Source files
------------

// File: rtl/wavetable_fetch_if.sv
// Bundle between the wavetable read stage, its ROM and the downstream interpolator.
// END exists only when WAVETABLE_FETCH_ONESHOT_EN is defined.
interface wavetable_fetch_if #(
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned TBL_W  = 2,
  parameter int unsigned LSB_W  = 10,
  parameter int unsigned DATA_W = 16
);
  localparam int unsigned PH_W = IDX_W + 6 + LSB_W;

  logic                     SAMPLE_TICK;
  logic [PH_W-1:0]          PHASE_INC;
  logic                     PHASE_RST;
  logic [TBL_W-1:0]         TABLE_SEL;
  logic [TBL_W+IDX_W-1:0]   ROM_ADDR;
  logic [DATA_W-1:0]        ROM_DATA;
  logic [DATA_W-1:0]        SAMPLE_1;
  logic [DATA_W-1:0]        SAMPLE_2;
  logic [5:0]               SEL;
  logic                     VALID;
  logic                     BUSY;
  logic                     OVERRUN;
`ifdef WAVETABLE_FETCH_ONESHOT_EN
  logic                     END;
`endif

  modport slave (
    input  SAMPLE_TICK, PHASE_INC, PHASE_RST, TABLE_SEL, ROM_DATA,
    output ROM_ADDR, SAMPLE_1, SAMPLE_2, SEL, VALID, BUSY, OVERRUN
`ifdef WAVETABLE_FETCH_ONESHOT_EN
    , output END
`endif
  );

  modport master (
    output SAMPLE_TICK, PHASE_INC, PHASE_RST, TABLE_SEL, ROM_DATA,
    input  ROM_ADDR, SAMPLE_1, SAMPLE_2, SEL, VALID, BUSY, OVERRUN
`ifdef WAVETABLE_FETCH_ONESHOT_EN
    , input END
`endif
  );
endinterface

// File: rtl/wavetable_fetch.sv
// Per-voice wavetable read stage: phase accumulator plus two-entry fetch from a synchronous ROM.
// Optional one-shot (saturating) playback via WAVETABLE_FETCH_ONESHOT_EN.
module wavetable_fetch #(
  parameter int unsigned IDX_W  = 8,
  parameter int unsigned TBL_W  = 2,
  parameter int unsigned LSB_W  = 10,
  parameter int unsigned DATA_W = 16
) (
  input  logic               CLK,
  input  logic               RESET,
  wavetable_fetch_if.slave   bus
);
  localparam int unsigned PH_W = IDX_W + 6 + LSB_W;

  typedef enum logic [1:0] {IDLE, RD1, RD2, RD3} state_t;

  state_t             state;
  logic [PH_W-1:0]    phase;
  logic [IDX_W-1:0]   idx_r;
  logic [5:0]         frac_r;
  logic [TBL_W-1:0]   tbl_r;
  logic [DATA_W-1:0]  s1_r;

  logic [PH_W-1:0]    base_c;
  logic [PH_W-1:0]    next_phase_c;
  logic [IDX_W-1:0]   idx2_c;
  logic               accept_c;

  // A coincident PHASE_RST makes the snapshot and the advance start from zero.
  assign base_c   = bus.PHASE_RST ? '0 : phase;
  assign accept_c = bus.SAMPLE_TICK && (state == IDLE);

`ifdef WAVETABLE_FETCH_ONESHOT_EN
  logic [PH_W:0] sum_c;
  logic          ovf_c;
  assign sum_c        = {1'b0, base_c} + {1'b0, bus.PHASE_INC};
  assign ovf_c        = sum_c[PH_W];
  assign next_phase_c = ovf_c ? '1 : sum_c[PH_W-1:0];
  // Last entry pairs with itself so playback never reads past the end.
  assign idx2_c       = (idx_r == {IDX_W{1'b1}}) ? idx_r : idx_r + IDX_W'(1);
`else
  assign next_phase_c = base_c + bus.PHASE_INC;
  assign idx2_c       = idx_r + IDX_W'(1);
`endif

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state        <= IDLE;
      phase        <= '0;
      idx_r        <= '0;
      frac_r       <= '0;
      tbl_r        <= '0;
      s1_r         <= '0;
      bus.ROM_ADDR <= '0;
      bus.SAMPLE_1 <= '0;
      bus.SAMPLE_2 <= '0;
      bus.SEL      <= '0;
      bus.VALID    <= 1'b0;
      bus.BUSY     <= 1'b0;
      bus.OVERRUN  <= 1'b0;
`ifdef WAVETABLE_FETCH_ONESHOT_EN
      bus.END      <= 1'b0;
`endif
    end else begin
      bus.VALID <= 1'b0;
      if (bus.PHASE_RST) begin
        phase <= '0;
`ifdef WAVETABLE_FETCH_ONESHOT_EN
        bus.END <= 1'b0;
`endif
      end
      if (bus.SAMPLE_TICK && !accept_c) bus.OVERRUN <= 1'b1;

      case (state)
        IDLE: begin
          if (accept_c) begin
            idx_r        <= base_c[PH_W-1 -: IDX_W];
            frac_r       <= base_c[LSB_W+5:LSB_W];
            tbl_r        <= bus.TABLE_SEL;
            phase        <= next_phase_c;
            bus.ROM_ADDR <= {bus.TABLE_SEL, base_c[PH_W-1 -: IDX_W]};
            bus.BUSY     <= 1'b1;
            state        <= RD1;
`ifdef WAVETABLE_FETCH_ONESHOT_EN
            if (ovf_c) bus.END <= 1'b1;
`endif
          end
        end
        RD1: begin
          bus.ROM_ADDR <= {tbl_r, idx2_c};
          state        <= RD2;
        end
        RD2: begin
          s1_r  <= bus.ROM_DATA;
          state <= RD3;
        end
        RD3: begin
          bus.SAMPLE_1 <= s1_r;
          bus.SAMPLE_2 <= bus.ROM_DATA;
          bus.SEL      <= frac_r;
          bus.VALID    <= 1'b1;
          bus.BUSY     <= 1'b0;
          state        <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_wavetable_fetch.sv
// Directed bench for wavetable_fetch; ROM model returns entry i as i*256 for every table.
module tb_wavetable_fetch;
  logic CLK;
  logic RESET;
  int   vectors;
  int   miscompares;

  wavetable_fetch_if #(.IDX_W(8), .TBL_W(2), .LSB_W(10), .DATA_W(16)) bus ();

  wavetable_fetch #(.IDX_W(8), .TBL_W(2), .LSB_W(10), .DATA_W(16)) dut (
    .CLK   (CLK),
    .RESET (RESET),
    .bus   (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  always @(posedge CLK) bus.ROM_DATA <= {bus.ROM_ADDR[7:0], 8'h00};

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(negedge CLK);
    RESET = 1'b0;
  endtask

  // Issue one tick at the current negedge and wait for VALID; lat = 99 on timeout.
  task automatic fetch(input logic [23:0] inc, input logic [1:0] tsel, input logic prst,
                       output logic [15:0] s1, output logic [15:0] s2, output logic [5:0] sel,
                       output int lat, output logic [9:0] a1, output logic [9:0] a2);
    int n;
    bus.PHASE_INC   = inc;
    bus.TABLE_SEL   = tsel;
    bus.PHASE_RST   = prst;
    bus.SAMPLE_TICK = 1'b1;
    n   = 0;
    lat = 99;
    a1  = '0;
    a2  = '0;
    while (n < 12 && lat == 99) begin
      @(negedge CLK);
      n++;
      bus.SAMPLE_TICK = 1'b0;
      bus.PHASE_RST   = 1'b0;
      if (n == 1) a1 = bus.ROM_ADDR;
      if (n == 2) a2 = bus.ROM_ADDR;
      if (bus.VALID) lat = n;
    end
    s1  = bus.SAMPLE_1;
    s2  = bus.SAMPLE_2;
    sel = bus.SEL;
  endtask

  task automatic test_reset();
    do_reset();
    vectors++;
    if ({bus.SAMPLE_1, bus.SAMPLE_2, bus.SEL, bus.VALID, bus.BUSY, bus.OVERRUN, bus.ROM_ADDR} !== '0) begin
      miscompares++;
      $display("FAIL reset_state: s1=%h s2=%h sel=%0d valid=%b busy=%b ovr=%b addr=%h, required all 0",
               bus.SAMPLE_1, bus.SAMPLE_2, bus.SEL, bus.VALID, bus.BUSY, bus.OVERRUN, bus.ROM_ADDR);
    end
  endtask

  task automatic test_basic();
    logic [15:0] s1, s2; logic [5:0] sel; int lat; logic [9:0] a1, a2;
    do_reset();
    for (int t = 1; t <= 65; t++) begin
      fetch(24'h000400, 2'd0, 1'b0, s1, s2, sel, lat, a1, a2);
      repeat (4) @(negedge CLK);
      vectors++;
      if (lat !== 4) begin
        miscompares++;
        $display("FAIL basic_latency tick %0d: got %0d, required 4", t, lat);
      end
      if (t == 1 || t == 2 || t == 65) begin
        logic [15:0] e1, e2; logic [5:0] es;
        e1 = (t == 65) ? 16'd256 : 16'd0;
        e2 = (t == 65) ? 16'd512 : 16'd256;
        es = (t == 2) ? 6'd1 : 6'd0;
        vectors++;
        if (s1 !== e1 || s2 !== e2 || sel !== es) begin
          miscompares++;
          $display("FAIL basic_tick%0d: s1=%h s2=%h sel=%0d, required s1=%h s2=%h sel=%0d",
                   t, s1, s2, sel, e1, e2, es);
        end
      end
    end
  endtask

  task automatic test_index_wrap();
    logic [15:0] s1, s2; logic [5:0] sel; int lat; logic [9:0] a1, a2;
    do_reset();
    for (int t = 1; t <= 257; t++) begin
      fetch(24'h010000, 2'd1, 1'b0, s1, s2, sel, lat, a1, a2);
      if (t == 256) begin
        vectors++;
        if (s1 !== 16'hFF00 || s2 !== 16'h0000 || a1 !== 10'h1FF || a2 !== 10'h100 || lat !== 4) begin
          miscompares++;
          $display("FAIL wrap_tick256: s1=%h s2=%h a1=%h a2=%h lat=%0d, required FF00 0000 1FF 100 4",
                   s1, s2, a1, a2, lat);
        end
      end
      if (t == 257) begin
        vectors++;
        if (s1 !== 16'h0000 || s2 !== 16'h0100 || a1 !== 10'h100) begin
          miscompares++;
          $display("FAIL wrap_tick257: s1=%h s2=%h a1=%h, required 0000 0100 100", s1, s2, a1);
        end
      end
    end
  endtask

  task automatic test_overrun();
    logic [15:0] s1, s2; logic [5:0] sel; int lat; logic [9:0] a1, a2;
    int nv, vat; logic ov2, ov3;
    do_reset();
    nv = 0; vat = 0; ov2 = 1'bx; ov3 = 1'bx;
    bus.PHASE_INC   = 24'h000400;
    bus.SAMPLE_TICK = 1'b1;
    for (int n = 1; n <= 8; n++) begin
      @(negedge CLK);
      if (bus.VALID) begin nv++; vat = n; end
      if (n == 2) ov2 = bus.OVERRUN;
      if (n == 3) ov3 = bus.OVERRUN;
      bus.SAMPLE_TICK = (n == 2);
    end
    vectors++;
    if (nv !== 1 || vat !== 4) begin
      miscompares++;
      $display("FAIL overrun_valid: count=%0d at=%0d, required count=1 at=4", nv, vat);
    end
    vectors++;
    if (ov2 !== 1'b0 || ov3 !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_flag: T+2=%b T+3=%b, required 0 1", ov2, ov3);
    end
    fetch(24'h000400, 2'd0, 1'b0, s1, s2, sel, lat, a1, a2);
    vectors++;
    if (sel !== 6'd1 || bus.OVERRUN !== 1'b1) begin
      miscompares++;
      $display("FAIL overrun_phase: sel=%0d ovr=%b, required sel=1 ovr=1", sel, bus.OVERRUN);
    end
  endtask

  task automatic test_reset_mid_fetch();
    logic [15:0] s1, s2; logic [5:0] sel; int lat; logic [9:0] a1, a2;
    logic ov_pre; int nv;
    do_reset();
    fetch(24'h010400, 2'd0, 1'b0, s1, s2, sel, lat, a1, a2);
    fetch(24'h010400, 2'd0, 1'b0, s1, s2, sel, lat, a1, a2);
    bus.SAMPLE_TICK = 1'b1;
    @(negedge CLK);
    @(negedge CLK);
    bus.SAMPLE_TICK = 1'b0;
    ov_pre = bus.OVERRUN;
    RESET = 1'b1;
    @(negedge CLK);
    RESET = 1'b0;
    vectors++;
    if (ov_pre !== 1'b1) begin
      miscompares++;
      $display("FAIL rstmid_pre_overrun: got %b, required 1", ov_pre);
    end
    vectors++;
    if ({bus.SAMPLE_1, bus.SAMPLE_2, bus.SEL, bus.ROM_ADDR, bus.OVERRUN, bus.VALID} !== '0) begin
      miscompares++;
      $display("FAIL rstmid_clear: s1=%h s2=%h sel=%0d addr=%h ovr=%b valid=%b, required all 0",
               bus.SAMPLE_1, bus.SAMPLE_2, bus.SEL, bus.ROM_ADDR, bus.OVERRUN, bus.VALID);
    end
    nv = 0;
    repeat (4) begin @(negedge CLK); if (bus.VALID) nv++; end
    vectors++;
    if (nv !== 0) begin
      miscompares++;
      $display("FAIL rstmid_no_valid: got %0d pulses, required 0", nv);
    end
    fetch(24'h000400, 2'd1, 1'b0, s1, s2, sel, lat, a1, a2);
    vectors++;
    if (s1 !== 16'h0000 || s2 !== 16'h0100 || sel !== 6'd0 || a1 !== 10'h100) begin
      miscompares++;
      $display("FAIL rstmid_next: s1=%h s2=%h sel=%0d a1=%h, required 0000 0100 0 100", s1, s2, sel, a1);
    end
  endtask

  task automatic test_phase_rst();
    logic [15:0] s1, s2; logic [5:0] sel; int lat; logic [9:0] a1, a2;
    do_reset();
    for (int t = 0; t < 10; t++) fetch(24'h000400, 2'd0, 1'b0, s1, s2, sel, lat, a1, a2);
    vectors++;
    if (sel !== 6'd9) begin
      miscompares++;
      $display("FAIL prst_pre: sel=%0d, required 9", sel);
    end
    fetch(24'h000400, 2'd2, 1'b1, s1, s2, sel, lat, a1, a2);
    vectors++;
    if (sel !== 6'd0 || s1 !== 16'h0000 || a1[9:8] !== 2'b10) begin
      miscompares++;
      $display("FAIL prst_tick: sel=%0d s1=%h tbl=%b, required 0 0000 10", sel, s1, a1[9:8]);
    end
    fetch(24'h000400, 2'd2, 1'b0, s1, s2, sel, lat, a1, a2);
    vectors++;
    if (sel !== 6'd1 || a2[9:8] !== 2'b10) begin
      miscompares++;
      $display("FAIL prst_follow: sel=%0d tbl=%b, required 1 10", sel, a2[9:8]);
    end
  endtask

`ifdef WAVETABLE_FETCH_ONESHOT_EN
  task automatic test_oneshot();
    logic [15:0] s1, s2; logic [5:0] sel; int lat; logic [9:0] a1, a2;
    do_reset();
    for (int t = 1; t <= 4; t++) begin
      fetch(24'h400000, 2'd0, 1'b0, s1, s2, sel, lat, a1, a2);
      vectors++;
      if (bus.END !== (t == 4)) begin
        miscompares++;
        $display("FAIL oneshot_end tick %0d: got %b, required %b", t, bus.END, (t == 4));
      end
    end
    for (int t = 0; t < 2; t++) begin
      fetch(24'h400000, 2'd0, 1'b0, s1, s2, sel, lat, a1, a2);
      vectors++;
      if (s1 !== 16'hFF00 || s2 !== 16'hFF00 || sel !== 6'd63) begin
        miscompares++;
        $display("FAIL oneshot_sat: s1=%h s2=%h sel=%0d, required FF00 FF00 63", s1, s2, sel);
      end
    end
    fetch(24'h400000, 2'd0, 1'b1, s1, s2, sel, lat, a1, a2);
    vectors++;
    if (bus.END !== 1'b0 || s1 !== 16'h0000) begin
      miscompares++;
      $display("FAIL oneshot_prst: end=%b s1=%h, required 0 0000", bus.END, s1);
    end
  endtask
`endif

  initial begin
    vectors         = 0;
    miscompares     = 0;
    RESET           = 1'b1;
    bus.SAMPLE_TICK = 1'b0;
    bus.PHASE_INC   = '0;
    bus.PHASE_RST   = 1'b0;
    bus.TABLE_SEL   = '0;
    @(negedge CLK);
    test_reset();
    test_basic();
    test_index_wrap();
    test_overrun();
    test_reset_mid_fetch();
    test_phase_rst();
`ifdef WAVETABLE_FETCH_ONESHOT_EN
    test_oneshot();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
